// File: rtl/main_memory_pkg.sv
// main_memory_pipe shared types, field widths and parameter checks.
// Imported by the response queue and the top level.
package main_memory_pkg;

  localparam int AGE_W   = 8;
  localparam int AGE_MAX = 255;
  localparam int OUT_MIN = 2;
  localparam int OUT_MAX = 16;
  localparam int DLY_MIN = 2;

  typedef struct packed {
    logic             read;
    logic [AGE_W-1:0] age;
    logic             data_vld;
  } rsp_meta_t;

  function automatic bit delay_ok(int d);
    return (d >= DLY_MIN) && (d <= AGE_MAX);
  endfunction

  function automatic bit outstanding_ok(int n);
    return (n >= OUT_MIN) && (n <= OUT_MAX)
        && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/main_memory_if.sv
// Command/response bus between the cache refill port and the
// pipelined main memory model.
interface main_memory_if #(
  parameter int ADDR_LEN  = 16,
  parameter int MEMORY_DW = 256,
  parameter int MEMORY_MW = 32
);

  logic                 memory_cs;
  logic                 memory_cmd_valid;
  logic                 memory_cmd_ready;
  logic                 memory_cmd_read;
  logic [ADDR_LEN-1:0]  memory_cmd_addr;
  logic [MEMORY_DW-1:0] memory_cmd_wdata;
  logic [MEMORY_MW-1:0] memory_cmd_wmask;
  logic                 memory_rsp_valid;
  logic                 memory_rsp_ready;
  logic [MEMORY_DW-1:0] memory_rsp_rdata;
  logic                 memory_rsp_write;

  modport master (
    output memory_cs,
    output memory_cmd_valid,
    output memory_cmd_read,
    output memory_cmd_addr,
    output memory_cmd_wdata,
    output memory_cmd_wmask,
    output memory_rsp_ready,
    input  memory_cmd_ready,
    input  memory_rsp_valid,
    input  memory_rsp_rdata,
    input  memory_rsp_write
  );

  modport slave (
    input  memory_cs,
    input  memory_cmd_valid,
    input  memory_cmd_read,
    input  memory_cmd_addr,
    input  memory_cmd_wdata,
    input  memory_cmd_wmask,
    input  memory_rsp_ready,
    output memory_cmd_ready,
    output memory_rsp_valid,
    output memory_rsp_rdata,
    output memory_rsp_write
  );

endinterface

// File: rtl/main_memory_rsp_q.sv
// In-order response queue: per-slot age, read flag and captured
// line; the head is offered once it is old enough and its data is in.
module main_memory_rsp_q
  import main_memory_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 256,
  parameter int DELAY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     push_read_i,
  input  logic                     cap_i,
  input  logic [$clog2(DEPTH)-1:0] cap_idx_i,
  input  logic [DW-1:0]            cap_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH)-1:0] wptr_o,
  output logic                     full_o,
  output logic                     head_ok_o,
  output logic                     head_read_o,
  output logic [DW-1:0]            head_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rsp_meta_t        meta_q [DEPTH];
  rsp_meta_t        meta_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d = meta_q;
    data_d = data_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (meta_q[i].age != AGE_W'(AGE_MAX))
        meta_d[i].age = meta_q[i].age + 1'b1;
    end
    if (cap_i) begin
      meta_d[cap_idx_i].data_vld = 1'b1;
      data_d[cap_idx_i]          = cap_data_i;
    end
    // Write acks carry no data, so they are complete on push.
    if (push_i) begin
      meta_d[wptr_q] = '{read:     push_read_i,
                         age:      '0,
                         data_vld: ~push_read_i};
      data_d[wptr_q] = '0;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop_i)
      rptr_d = rptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
        data_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      data_q <= data_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wptr_o      = wptr_q;
  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign head_ok_o   = (cnt_q != '0)
                     && meta_q[rptr_q].data_vld
                     && (meta_q[rptr_q].age >= AGE_W'(DELAY));
  assign head_read_o = meta_q[rptr_q].read;
  assign head_data_o = data_q[rptr_q];

endmodule

// File: rtl/sirv_gnrl_ram.sv
// Single-port line-wide RAM with byte write enables and a
// registered read port (one cycle read latency).
module sirv_gnrl_ram #(
  parameter int DP           = 512,
  parameter int DW           = 32,
  parameter int MW           = 4,
  parameter int AW           = 9,
  parameter int FORCE_X2ZERO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic [MW-1:0] wem,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_r [DP];
  logic [DW-1:0] dout_q;
  logic          rd_seen_q;
  logic          rd_seen_d;

  always_ff @(posedge clk) begin
    if (cs & we) begin
      for (int i = 0; i < MW; i++) begin
        if (wem[i])
          mem_r[addr][i*8 +: 8] <= din[i*8 +: 8];
      end
    end
    if (cs & ~we)
      dout_q <= mem_r[addr];
  end

  assign rd_seen_d = rd_seen_q | (cs & ~we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_seen_q <= 1'b0;
    else
      rd_seen_q <= rd_seen_d;
  end

  // Until the first read the output register holds nothing defined.
  assign dout = ((FORCE_X2ZERO != 0) && !rd_seen_q)
              ? '0 : dout_q;

endmodule

// File: rtl/main_memory_pipe.sv
// Pipelined main memory: OUTSTANDING in-order commands, DELAY minimum
// latency. MAIN_MEMORY_WRITE_RSP_EN adds write acks; FPGA_SOURCE RAM.
module main_memory_pipe
  import main_memory_pkg::*;
#(
  parameter int ADDR_LEN    = 16,
  parameter int MEMORY_DW   = 256,
  parameter int MEMORY_MW   = 32,
  parameter int OFFSET_LEN  = 2,
  parameter int DELAY       = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  main_memory_if.slave mem
);

  localparam int IDX_W = ADDR_LEN - OFFSET_LEN;
  localparam int PTR_W = $clog2(OUTSTANDING);

`ifdef MAIN_MEMORY_WRITE_RSP_EN
  localparam bit WR_RSP = 1'b1;
`else
  localparam bit WR_RSP = 1'b0;
`endif

`ifdef FPGA_SOURCE
  localparam int X2Z = 0;
`else
  localparam int X2Z = 1;
`endif

  if (!delay_ok(DELAY)) begin : g_bad_delay
    $error("main_memory_pipe: DELAY out of range");
  end
  if (!outstanding_ok(OUTSTANDING)) begin : g_bad_out
    $error("main_memory_pipe: bad OUTSTANDING");
  end
  if (MEMORY_DW != MEMORY_MW * 8) begin : g_bad_dw
    $error("main_memory_pipe: MEMORY_DW != 8*MW");
  end

  logic                 acc;
  logic                 rd;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 head_ok;
  logic                 head_read;
  logic [MEMORY_DW-1:0] head_data;
  logic [PTR_W-1:0]     wptr;
  logic [IDX_W-1:0]     idx;
  logic [MEMORY_DW-1:0] ram_dout;
  logic                 unused_ok;

  logic                 ram_cs_q, ram_cs_d;
  logic                 ram_we_q, ram_we_d;
  logic [IDX_W-1:0]     ram_idx_q, ram_idx_d;
  logic [MEMORY_DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [MEMORY_MW-1:0] ram_wmask_q, ram_wmask_d;
  logic                 cap1_vld_q, cap1_vld_d;
  logic [PTR_W-1:0]     cap1_idx_q, cap1_idx_d;
  logic                 cap2_vld_q, cap2_vld_d;
  logic [PTR_W-1:0]     cap2_idx_q, cap2_idx_d;

  assign rd  = mem.memory_cmd_read;
  assign idx = mem.memory_cmd_addr[ADDR_LEN-1:OFFSET_LEN];
  assign acc = mem.memory_cs
             & mem.memory_cmd_valid
             & mem.memory_cmd_ready;
  assign push = acc & (rd | WR_RSP);
  assign pop  = head_ok & mem.memory_rsp_ready;

  assign unused_ok =
    ^mem.memory_cmd_addr[OFFSET_LEN-1:0];

  // Read data leaves the RAM two edges after accept; the slot
  // index rides along so the right entry captures it.
  always_comb begin
    ram_cs_d    = acc;
    ram_we_d    = acc & ~rd;
    ram_wmask_d = (acc & ~rd)
                ? mem.memory_cmd_wmask : '0;
    ram_idx_d   = acc ? idx : ram_idx_q;
    ram_wdata_d = acc ? mem.memory_cmd_wdata
                      : ram_wdata_q;
    cap1_vld_d  = acc & rd;
    cap1_idx_d  = acc ? wptr : cap1_idx_q;
    cap2_vld_d  = cap1_vld_q;
    cap2_idx_d  = cap1_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_idx_q   <= '0;
      ram_wdata_q <= '0;
      ram_wmask_q <= '0;
      cap1_vld_q  <= 1'b0;
      cap1_idx_q  <= '0;
      cap2_vld_q  <= 1'b0;
      cap2_idx_q  <= '0;
    end else begin
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_idx_q   <= ram_idx_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wmask_q <= ram_wmask_d;
      cap1_vld_q  <= cap1_vld_d;
      cap1_idx_q  <= cap1_idx_d;
      cap2_vld_q  <= cap2_vld_d;
      cap2_idx_q  <= cap2_idx_d;
    end
  end

  sirv_gnrl_ram #(
    .DP           (2 ** IDX_W),
    .DW           (MEMORY_DW),
    .MW           (MEMORY_MW),
    .AW           (IDX_W),
    .FORCE_X2ZERO (X2Z)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (ram_cs_q),
    .we    (ram_we_q),
    .addr  (ram_idx_q),
    .din   (ram_wdata_q),
    .wem   (ram_wmask_q),
    .dout  (ram_dout)
  );

  main_memory_rsp_q #(
    .DEPTH (OUTSTANDING),
    .DW    (MEMORY_DW),
    .DELAY (DELAY)
  ) u_rsp_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_read_i (rd),
    .cap_i       (cap2_vld_q),
    .cap_idx_i   (cap2_idx_q),
    .cap_data_i  (ram_dout),
    .pop_i       (pop),
    .wptr_o      (wptr),
    .full_o      (full),
    .head_ok_o   (head_ok),
    .head_read_o (head_read),
    .head_data_o (head_data)
  );

  assign mem.memory_cmd_ready = ~full;
  assign mem.memory_rsp_valid = head_ok;
  assign mem.memory_rsp_rdata = head_ok
                              ? head_data : '0;
  assign mem.memory_rsp_write = WR_RSP
                              & head_ok
                              & ~head_read;

endmodule

// File: tb/tb_main_memory_pipe.sv
// Self-checking bench for main_memory_pipe: table of commands,
// scoreboard of in-order responses, hand-written corner sequences.
module tb_main_memory_pipe;

  localparam int AL  = 16;
  localparam int DW  = 256;
  localparam int MW  = 32;
  localparam int OFF = 2;
  localparam int DLY = 2;
  localparam int OUT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  main_memory_if #(
    .ADDR_LEN  (AL),
    .MEMORY_DW (DW),
    .MEMORY_MW (MW)
  ) bus ();

  main_memory_pipe #(
    .ADDR_LEN    (AL),
    .MEMORY_DW   (DW),
    .MEMORY_MW   (MW),
    .OFFSET_LEN  (OFF),
    .DELAY       (DLY),
    .OUTSTANDING (OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (bus)
  );

  typedef struct {
    bit            rd;
    logic [AL-1:0] addr;
    logic [MW-1:0] mask;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    bit            wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb [$];
  int            checks = 0;
  int            errors = 0;
  bit            pv     = 1'b0;
  logic [DW-1:0] pdata  = '0;

  function automatic logic [DW-1:0] line(logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic check(string name,
                       logic [DW-1:0] act,
                       logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    bus.memory_cs        = 1'b1;
    bus.memory_cmd_valid = 1'b0;
    bus.memory_cmd_read  = 1'b0;
    bus.memory_cmd_addr  = '0;
    bus.memory_cmd_wdata = '0;
    bus.memory_cmd_wmask = '0;
  endtask

  task automatic drive(vec_t v);
    bus.memory_cs        = 1'b1;
    bus.memory_cmd_valid = 1'b1;
    bus.memory_cmd_read  = v.rd;
    bus.memory_cmd_addr  = v.addr;
    bus.memory_cmd_wdata = v.wdata;
    bus.memory_cmd_wmask = v.mask;
  endtask

  task automatic wait_accept(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.memory_cmd_ready & bus.memory_cs;
    end
    @(posedge clk);
    #1;
    check(name, DW'(ok), DW'(1));
  endtask

  task automatic push_exp(vec_t v);
    if (v.rd)
      sb.push_back('{1'b0, v.exp});
`ifdef MAIN_MEMORY_WRITE_RSP_EN
    else
      sb.push_back('{1'b1, '0});
`endif
  endtask

  task automatic issue(vec_t v, string name);
    drive(v);
    wait_accept(name);
    push_exp(v);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check({"drain_", name}, DW'(sb.size()), '0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv) begin
        check("hold_valid",
              DW'(bus.memory_rsp_valid), DW'(1));
        check("hold_rdata", bus.memory_rsp_rdata, pdata);
      end
      if (bus.memory_rsp_valid && bus.memory_rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", DW'(1), DW'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", bus.memory_rsp_rdata, e.data);
          check("rsp_write",
                DW'(bus.memory_rsp_write), DW'(e.wr));
        end
      end
      pv    = bus.memory_rsp_valid & ~bus.memory_rsp_ready;
      pdata = bus.memory_rsp_rdata;
    end
  endtask

  task automatic run();
    vec_t          vt [13];
    vec_t          v;
    logic [DW-1:0] e;
    int            lat;

    idle();
    bus.memory_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", DW'(bus.memory_cmd_ready), DW'(1));
    check("rst_rsp_valid", DW'(bus.memory_rsp_valid), DW'(0));
    check("rst_rsp_rdata", bus.memory_rsp_rdata, '0);
    check("rst_rsp_write", DW'(bus.memory_rsp_write), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vt[0] = '{1'b0, 16'h0040, 32'hFFFF_FFFF, line(8'hA5), '0};
    vt[1] = '{1'b1, 16'h0040, '0, '0, line(8'hA5)};
    vt[2] = '{1'b0, 16'h0080, 32'hFFFF_FFFF, line(8'h11), '0};
    vt[3] = '{1'b0, 16'h0080, 32'h0000_0001, line(8'hEE), '0};
    e = line(8'h11);
    e[7:0] = 8'hEE;
    vt[4] = '{1'b1, 16'h0080, '0, '0, e};
    vt[5] = '{1'b0, 16'h00C0, 32'hFFFF_FFFF, line(8'h3C), '0};
    vt[6] = '{1'b1, 16'h00C0, '0, '0, line(8'h3C)};
    vt[7] = '{1'b0, 16'h0100, 32'hFFFF_FFFF, line(8'h22), '0};
    vt[8] = '{1'b0, 16'h0100, 32'hF000_0000, line(8'h77), '0};
    e = line(8'h22);
    e[255:224] = 32'h7777_7777;
    vt[9]  = '{1'b1, 16'h0100, '0, '0, e};
    vt[10] = '{1'b1, 16'h0043, '0, '0, line(8'hA5)};
    vt[11] = '{1'b0, 16'hFFFC, 32'hFFFF_FFFF, line(8'hC3), '0};
    vt[12] = '{1'b1, 16'hFFFF, '0, '0, line(8'hC3)};

    for (int i = 0; i < 13; i++)
      issue(vt[i], "table_accept");
    idle();
    drain("table");

    issue(vt[1], "lat_accept");
    idle();
    lat = 0;
    while (!bus.memory_rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", DW'(lat), DW'(DLY));
    drain("latency");

    v = vt[1];
    drive(v);
    bus.memory_cs = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("cs_ready", DW'(bus.memory_cmd_ready), DW'(1));
    end
    check("cs_no_rsp", DW'(bus.memory_rsp_valid), DW'(0));
    issue(vt[1], "cs_accept");
    idle();
    drain("cs");

    bus.memory_rsp_ready = 1'b0;
    issue(vt[1], "bp_accept");
    issue(vt[4], "bp_accept");
    issue(vt[6], "bp_accept");
    issue(vt[9], "bp_accept");
    check("bp_full_ready", DW'(bus.memory_cmd_ready), DW'(0));
    drive(vt[12]);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_ready_low", DW'(bus.memory_cmd_ready), DW'(0));
      check("bp_valid", DW'(bus.memory_rsp_valid), DW'(1));
      check("bp_head", bus.memory_rsp_rdata, line(8'hA5));
    end
    bus.memory_rsp_ready = 1'b1;
    wait_accept("bp_fifth_accept");
    push_exp(vt[12]);
    idle();
    drain("bp");

    bus.memory_rsp_ready = 1'b0;
    issue(vt[1], "rst_seq_accept");
    issue(vt[4], "rst_seq_accept");
    issue(vt[6], "rst_seq_accept");
    idle();
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_valid", DW'(bus.memory_rsp_valid), DW'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", DW'(bus.memory_rsp_valid), DW'(0));
    check("mid_rst_ready", DW'(bus.memory_cmd_ready), DW'(1));
    check("mid_rst_rdata", bus.memory_rsp_rdata, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.memory_rsp_ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("post_rst_valid", DW'(bus.memory_rsp_valid), DW'(0));
    end

    issue(vt[1], "post_rst_accept");
    idle();
    drain("post_rst");
  endtask

  initial begin
    fork
      monitor();
      run();
    join_any
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/main_memory_pipe.md
# main_memory_pipe

Pipelined, parametrised successor to the single-outstanding main memory model: accepts up to OUTSTANDING commands back-to-back, returns read data strictly in order after a programmable minimum latency, and holds response data stable under back-pressure. It sits behind the cache refill/writeback port and wraps one sirv_gnrl_ram line-wide array.

## Interface
- ADDR_LEN, 16: byte address width.
- MEMORY_DW, 256: line width in bits; MEMORY_DW = MEMORY_MW*8.
- MEMORY_MW, 32: byte-enable width.
- OFFSET_LEN, 2: low address bits dropped to form RAM index.
- DELAY, 2: minimum accept-to-response latency in cycles; legal range 2..255.
- OUTSTANDING, 4: response queue depth; power of two, 2..16.
- clk  in  1  clock; sole clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- memory_cs  in  1  chip select; gates acceptance only.
- memory_cmd_valid  in  1  command valid.
- memory_cmd_ready  out  1  command ready.
- memory_cmd_read  in  1  1 = read, 0 = write.
- memory_cmd_addr  in  ADDR_LEN  byte address; index = addr[ADDR_LEN-1:OFFSET_LEN].
- memory_cmd_wdata  in  MEMORY_DW  write data.
- memory_cmd_wmask  in  MEMORY_MW  per-byte write enable.
- memory_rsp_valid  out  1  response valid.
- memory_rsp_ready  in  1  response ready.
- memory_rsp_rdata  out  MEMORY_DW  read data; zero for write responses.
- memory_rsp_write  out  1  response is a write acknowledge.

## Operation
- Accept: acc = memory_cs & memory_cmd_valid & memory_cmd_ready; memory_cmd_ready = (count < OUTSTANDING). No same-cycle bypass: full queue deasserts ready even while head retires.
- Accepted command registers {we, index, wdata, wmask} into the RAM port next cycle; we/wmask pulse one cycle, default 0.
- Reads: entry {read=1, age=0} pushed on accept; RAM dout captured into the entry's data slot two cycles after accept.
- Writes: RAM updated one cycle after accept; entry pushed only with WRITE_RSP_EN.
- Age counters increment each cycle, saturate at 255. Head is eligible when age >= DELAY and data captured.
- memory_rsp_valid = head eligible; retire on valid & ready; rdata/write held stable while valid & !ready.
- count: +1 on push, -1 on retire, unchanged when both.
- memory_cs low: no acceptance; queued responses still drain.
- Read-after-write to same index accepted on consecutive cycles returns new data.

## Timing
- Reset values: memory_cmd_ready=1 (cs-independent), memory_rsp_valid=0, memory_rsp_rdata=0, memory_rsp_write=0; count=0, queue empty, RAM contents undefined/unchanged.
- Command accepted cycle T → response valid earliest at edge T+DELAY; throughput one command/cycle until full.
- Reset asserted mid-operation: all pending entries discarded immediately; writes already registered into the RAM port may or may not land.
- Wrap-around: read/write pointers mod OUTSTANDING; full = count==OUTSTANDING, empty = count==0.

## Configuration
- MAIN_MEMORY_WRITE_RSP_EN defined: every write produces an in-order response (memory_rsp_write=1, rdata=0) and occupies a queue slot.
- Undefined: writes complete silently, never occupy a slot; memory_rsp_write tied 0.

## Structure
- Shared package main_memory_pkg: entry field widths, AGE_W=8, AGE_MAX=255, legal-range checks for DELAY/OUTSTANDING.
- One sub-module main_memory_rsp_q: circular queue of {read, age, data_vld, data} with push/capture/pop; top holds accept logic and sirv_gnrl_ram (FORCE_X2ZERO=0 under FPGA_SOURCE, else 1).

## Test plan
- Write 0xA5.. line to addr 0x0040 mask all-ones, then read 0x0040 → rsp_valid exactly DELAY cycles after read accept, rdata equals written line.
- 4 back-to-back reads (OUTSTANDING=4) with rsp_ready=0 → cmd_ready drops after 4th; 5th waits; responses return in issue order once ready=1.
- Hold rsp_ready=0 for 10 cycles with valid head → rdata unchanged each cycle, no retire.
- Partial write mask 0x0000_0001 at 0x0080 → read returns only byte 0 changed.
- With MAIN_MEMORY_WRITE_RSP_EN: write then read → first rsp write=1 rdata=0, second write=0.
- Deassert rst_n with 3 reads pending → rsp_valid=0 and ready=1 same cycle, no responses after release.
